seq_mul_unit: RTL and testbench
===============================

Name: seq_mul_unit

Overview:
- Parametrised iterative shift-add multiplier for the CPU's MULT/MULTU path. It supersedes the fixed 32-bit unsigned multiplier.
- Adds signed/unsigned mode, an explicit start/busy/done handshake, synchronous reset, and a product register that holds its value between operations.
- Sits beside the ALU. The control unit issues start, then stalls on busy; the HI/LO registers load from product when done pulses.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH. Legal range 4..64.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request a multiply; sampled on the rising edge
- is_signed  input  1  1 = two's-complement operands (MULT), 0 = unsigned (MULTU); sampled with start
- dataA  input  WIDTH  multiplicand; sampled with start
- dataB  input  WIDTH  multiplier; sampled with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse: product is valid and newly updated
- MulAns  output  2*WIDTH  registered product; held until the next completion
- hi  output  WIDTH  MulAns[2*WIDTH-1:WIDTH]
- lo  output  WIDTH  MulAns[WIDTH-1:0]

Behaviour:
- Reset (sync, at posedge with reset=1) has priority over every other input:
  - state=IDLE, busy=0, done=0, MulAns=0.
  - Internal registers (BR, QR, acc, SC, neg flag) are cleared.
- An operation in progress when reset asserts is aborted. No done is produced and MulAns=0.
- States are IDLE and RUN. The done output is a registered pulse, not a state.
- IDLE → RUN: at an edge where start=1 and state=IDLE.
  - Signed mode: magA=|dataA|, magB=|dataB|, neg=dataA[MSB]^dataB[MSB].
  - Unsigned mode: magA=dataA, magB=dataB, neg=0.
  - BR={WIDTH'b0, magA}, QR=magB, acc=0, SC=0, busy=1.
  - Magnitude of the most-negative value is 2^(WIDTH-1), which is representable unsigned in WIDTH bits.
- RUN, each edge:
  - If QR[0]=1: acc=acc+BR (2*WIDTH-bit add; no overflow is possible).
  - Then BR<<=1, QR>>=1, SC++.
- RUN → IDLE at the edge where SC reaches WIDTH (the WIDTH-th RUN edge):
  - MulAns = neg ? -(final acc) : final acc (2*WIDTH-bit two's-complement negate).
  - done=1 for exactly that following cycle; busy=0.
- Latency: start seen at edge N means done=1 and MulAns valid in the cycle after edge N+WIDTH.
- busy is high from the cycle after edge N through the cycle after edge N+WIDTH-1.
- MulAns changes only on completion (or reset). Partial sums are never visible.
- start while busy=1 is ignored; the operands are not re-sampled.
- start in the done cycle (state is IDLE) is accepted, giving back-to-back operations with no dead cycle. done and busy may both be 1 in the cycle after that edge only if WIDTH=1, which is illegal, so done and busy are never both high.
- Zero operands take the full WIDTH cycles; there is no early termination.
- is_signed, dataA and dataB may change freely after the start edge.

Test Plan:
- Reset, then unsigned 3*5, start at edge 0 → busy high for 32 cycles; done pulse after edge 32; MulAns=0x0000_0000_0000_000F.
- Signed -3*5 (dataA=0xFFFF_FFFD, dataB=5) → MulAns=0xFFFF_FFFF_FFFF_FFF1. The same operands unsigned → MulAns=0x0000_0004_FFFF_FFF1.
- Unsigned 0xFFFF_FFFF*0xFFFF_FFFF → MulAns=0xFFFF_FFFE_0000_0001, hi=0xFFFF_FFFE, lo=0x0000_0001. Signed 0x8000_0000*0x8000_0000 → 0x4000_0000_0000_0000.
- start re-pulsed with new operands at cycle 10 of a busy operation → ignored; the original result appears with done at the original time. A start in the done cycle → second result follows exactly 32 cycles later.
- reset asserted at cycle 15 of an operation → next cycle busy=0, done=0, MulAns=0; no done pulse ever follows. A new start then completes normally.
- WIDTH=8 instance, signed 0x80*0x7F → done after 8 cycles; MulAns=0xC080.

Source files
------------

// File: rtl/seq_mul_unit.sv
// ---------------------------------------------------------------------------
// seq_mul_unit
//
// Iterative shift-add multiplier for the MULT / MULTU path. One operand bit
// is consumed per clock, so a multiply takes exactly WIDTH cycles after the
// start edge. Signed operation works on magnitudes and re-applies the sign
// to the final 2*WIDTH-bit sum.
//
// Parameters
//   WIDTH   operand width in bits (legal 4..64); product is 2*WIDTH bits
//   CNT_W   iteration counter width, derived from WIDTH
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; overrides every other input
//   start      request a multiply (sampled on the rising edge)
//   is_signed  1 = two's-complement operands, 0 = unsigned; sampled with start
//   dataA      multiplicand, sampled with start
//   dataB      multiplier, sampled with start
//   busy       high while an operation is in progress
//   done       one-cycle pulse: MulAns has just been updated
//   MulAns     registered product, held until the next completion
//   hi         upper half of MulAns
//   lo         lower half of MulAns
//
// Handshake: a request is accepted at a rising edge where start=1 and the
// unit is idle (busy=0). Operands may change freely after that edge. While
// busy=1, start is ignored and nothing is re-sampled. The result is valid in
// the cycle where done=1; that cycle is idle, so a start asserted during it
// is accepted immediately (back-to-back, no dead cycle). done and busy are
// never high together.
// ---------------------------------------------------------------------------
module seq_mul_unit #(
  parameter int  WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     dataA,
  input  logic [WIDTH-1:0]     dataB,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   MulAns,
  output logic [WIDTH-1:0]     hi,
  output logic [WIDTH-1:0]     lo
);

  localparam int PW = 2 * WIDTH;

  // Counter value seen on the final RUN edge; on that edge the count
  // reaches WIDTH and the result is committed.
  localparam logic [CNT_W-1:0] SC_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] SC_ONE  = CNT_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t           state,     state_nxt;
  logic [PW-1:0]    br,        br_nxt;      // shifted multiplicand
  logic [WIDTH-1:0] qr,        qr_nxt;      // remaining multiplier bits
  logic [PW-1:0]    acc,       acc_nxt;     // running magnitude sum
  logic [CNT_W-1:0] sc,        sc_nxt;      // iterations completed
  logic             neg,       neg_nxt;     // result sign for signed mode
  logic [PW-1:0]    mul_ans_q, mul_ans_nxt;
  logic             done_q,    done_nxt;

  // -------------------------------------------------------------------------
  // Operand conditioning at the start edge
  // -------------------------------------------------------------------------
  // The magnitude of the most-negative value, 2^(WIDTH-1), still fits in
  // WIDTH bits when read as unsigned, so a plain negate is enough.
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             neg_in;

  always_comb begin
    mag_a  = dataA;
    mag_b  = dataB;
    neg_in = 1'b0;
    if (is_signed) begin
      if (dataA[WIDTH-1]) mag_a = -dataA;
      if (dataB[WIDTH-1]) mag_b = -dataB;
      neg_in = dataA[WIDTH-1] ^ dataB[WIDTH-1];
    end
  end

  // -------------------------------------------------------------------------
  // Datapath step: conditional add of the shifted multiplicand
  // -------------------------------------------------------------------------
  // acc + br never overflows 2*WIDTH bits: both operands are at most
  // WIDTH-bit magnitudes, so the full product fits.
  logic [PW-1:0] acc_sum;
  logic [PW-1:0] acc_signed;

  always_comb begin
    acc_sum    = qr[0] ? (acc + br) : acc;
    acc_signed = neg ? -acc_sum : acc_sum;
  end

  // -------------------------------------------------------------------------
  // Next-state / next-data logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    br_nxt      = br;
    qr_nxt      = qr;
    acc_nxt     = acc;
    sc_nxt      = sc;
    neg_nxt     = neg;
    mul_ans_nxt = mul_ans_q;
    done_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          br_nxt    = {{WIDTH{1'b0}}, mag_a};
          qr_nxt    = mag_b;
          acc_nxt   = '0;
          sc_nxt    = '0;
          neg_nxt   = neg_in;
        end
      end

      RUN: begin
        // No early exit on zero operands: latency is always WIDTH edges.
        acc_nxt = acc_sum;
        br_nxt  = br << 1;
        qr_nxt  = qr >> 1;
        sc_nxt  = sc + SC_ONE;
        if (sc == SC_LAST) begin
          state_nxt   = IDLE;
          mul_ans_nxt = acc_signed;
          done_nxt    = 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      br        <= '0;
      qr        <= '0;
      acc       <= '0;
      sc        <= '0;
      neg       <= 1'b0;
      mul_ans_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      br        <= br_nxt;
      qr        <= qr_nxt;
      acc       <= acc_nxt;
      sc        <= sc_nxt;
      neg       <= neg_nxt;
      mul_ans_q <= mul_ans_nxt;
      done_q    <= done_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign busy   = (state == RUN);
  assign done   = done_q;
  assign MulAns = mul_ans_q;
  assign hi     = mul_ans_q[PW-1:WIDTH];
  assign lo     = mul_ans_q[WIDTH-1:0];

endmodule

// File: tb/tb_seq_mul_unit.sv
// ---------------------------------------------------------------------------
// tb_seq_mul_unit
//
// Directed bench for seq_mul_unit: a 32-bit instance driven from a vector
// table (run back-to-back, each start issued in the previous done cycle),
// hand-written sequences for the restart-ignore and mid-operation reset
// cases, and an 8-bit instance for a narrow-width check.
// ---------------------------------------------------------------------------
module tb_seq_mul_unit;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // 32-bit instance
  logic        start, is_signed;
  logic [31:0] a, b;
  logic        busy, done;
  logic [63:0] mul_ans;
  logic [31:0] hi, lo;

  // 8-bit instance
  logic        start_8, is_signed_8;
  logic [7:0]  a_8, b_8;
  logic        busy_8, done_8;
  logic [15:0] mul_ans_8;
  logic [7:0]  hi_8, lo_8;

  seq_mul_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .dataA     (a),
    .dataB     (b),
    .busy      (busy),
    .done      (done),
    .MulAns    (mul_ans),
    .hi        (hi),
    .lo        (lo)
  );

  seq_mul_unit #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .reset     (reset),
    .start     (start_8),
    .is_signed (is_signed_8),
    .dataA     (a_8),
    .dataB     (b_8),
    .busy      (busy_8),
    .done      (done_8),
    .MulAns    (mul_ans_8),
    .hi        (hi_8),
    .lo        (lo_8)
  );

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;
  logic [63:0] last32;   // result the 32-bit unit should currently hold
  logic [15:0] last8;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic run32(input logic sig, input logic [31:0] da, input logic [31:0] db,
                       input logic [63:0] exp, input string name);
    int   n;
    logic held;
    start = 1'b1; is_signed = sig; a = da; b = db;
    tick();
    // Scramble inputs after the start edge; they must not matter.
    start = 1'b0; is_signed = ~sig; a = $urandom; b = $urandom;
    chk1({name, " busy after start"}, busy, 1'b1);
    chk1({name, " no done after start"}, done, 1'b0);
    n = 0; held = 1'b1;
    while (!done && n < 100) begin
      if (mul_ans !== last32) held = 1'b0;
      tick();
      n++;
    end
    chk({name, " latency"}, 64'(n), 64'd32);
    chk1({name, " MulAns held while busy"}, held, 1'b1);
    chk({name, " MulAns"}, mul_ans, exp);
    chk({name, " hi"}, 64'(hi), 64'(exp[63:32]));
    chk({name, " lo"}, 64'(lo), 64'(exp[31:0]));
    chk1({name, " busy low at done"}, busy, 1'b0);
    last32 = exp;
  endtask

  task automatic run8(input logic sig, input logic [7:0] da, input logic [7:0] db,
                      input logic [15:0] exp, input string name);
    int n;
    start_8 = 1'b1; is_signed_8 = sig; a_8 = da; b_8 = db;
    tick();
    start_8 = 1'b0; a_8 = 8'($urandom); b_8 = 8'($urandom);
    chk1({name, " busy after start"}, busy_8, 1'b1);
    n = 0;
    while (!done_8 && n < 40) begin
      tick();
      n++;
    end
    chk({name, " latency"}, 64'(n), 64'd8);
    chk({name, " MulAns"}, 64'(mul_ans_8), 64'(exp));
    chk({name, " hi"}, 64'(hi_8), 64'(exp[15:8]));
    chk({name, " lo"}, 64'(lo_8), 64'(exp[7:0]));
    last8 = exp;
  endtask

  // -------------------------------------------------------------------------
  // Vector table
  // -------------------------------------------------------------------------
  typedef struct {
    logic        sig;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    string       name;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  initial begin
    int   n;
    logic seen;

    vecs[0] = '{1'b0, 32'd3,         32'd5,         64'h0000_0000_0000_000F, "u 3*5"};
    vecs[1] = '{1'b1, 32'hFFFF_FFFD, 32'd5,         64'hFFFF_FFFF_FFFF_FFF1, "s -3*5"};
    vecs[2] = '{1'b0, 32'hFFFF_FFFD, 32'd5,         64'h0000_0004_FFFF_FFF1, "u fffffffd*5"};
    vecs[3] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "u max*max"};
    vecs[4] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "s min*min"};
    vecs[5] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 64'h0000_0000_0000_0000, "s 0*-1"};
    vecs[6] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, "s -1*-1"};
    vecs[7] = '{1'b1, 32'd7,         32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF2, "s 7*-2"};
    vecs[8] = '{1'b0, 32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780, "u shift16"};
    vecs[9] = '{1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, "s max*min"};

    reset = 1'b1;
    start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    start_8 = 1'b0; is_signed_8 = 1'b0; a_8 = '0; b_8 = '0;
    last32 = '0; last8 = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    chk1("reset busy", busy, 1'b0);
    chk1("reset done", done, 1'b0);
    chk("reset MulAns", mul_ans, 64'd0);
    chk1("reset busy w8", busy_8, 1'b0);
    chk("reset MulAns w8", 64'(mul_ans_8), 64'd0);

    // Table: each call starts in the done cycle of the previous one.
    for (int i = 0; i < NV; i++) begin
      run32(vecs[i].sig, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
    end
    tick();
    chk1("done is one cycle", done, 1'b0);

    // Restart while busy is ignored: original result at original time.
    start = 1'b1; is_signed = 1'b0; a = 32'd3; b = 32'd5;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      if (n == 10) begin
        start = 1'b1; is_signed = 1'b1; a = 32'd7; b = 32'd9;
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    chk("restart latency", 64'(n), 64'd32);
    chk("restart MulAns", mul_ans, 64'h0000_0000_0000_000F);
    last32 = 64'h0000_0000_0000_000F;
    tick();
    chk1("restart not queued", busy, 1'b0);

    // Reset in the middle of an operation aborts it.
    start = 1'b1; is_signed = 1'b0; a = 32'd11; b = 32'd13;
    tick();
    start = 1'b0;
    repeat (14) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk1("abort busy", busy, 1'b0);
    chk1("abort done", done, 1'b0);
    chk("abort MulAns", mul_ans, 64'd0);
    last32 = '0;
    seen = 1'b0;
    repeat (40) begin
      if (done || busy) seen = 1'b1;
      tick();
    end
    chk1("no done after abort", seen, 1'b0);
    chk("MulAns stays 0 after abort", mul_ans, 64'd0);
    run32(1'b0, 32'd6, 32'd7, 64'd42, "after abort 6*7");

    // Narrow instance
    run8(1'b1, 8'h80, 8'h7F, 16'hC080, "w8 s 80*7f");
    run8(1'b0, 8'hFF, 8'hFF, 16'hFE01, "w8 u ff*ff");
    run8(1'b1, 8'hFD, 8'h05, 16'hFFF1, "w8 s -3*5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
